// File: rtl/forward_buffer.sv
// forward_buffer: operand forwarding network for a pipelined core.
// Operands are looked up combinationally, with this priority:
//   EX producer, then MEM producer, then the history of committed writebacks
//   from newest to oldest.
// The first match wins. If the match is a producer whose result is not ready,
// the lookup requests a stall instead of forwarding.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no port is waiting on a producer; stall_cnt held at 0
// STALL | at least one port waits on a not-ready producer; stall_cnt counts
module forward_buffer #(
    parameter int NSRC     = 2,
    parameter int DEPTH    = 4,
    parameter int DATAW    = 32,
    parameter int REGW     = 5,
    parameter int MAXSTALL = 15
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             regWr_ex,
    input  logic [REGW-1:0]                  regDst_ex,
    input  logic [DATAW-1:0]                 res_ex,
    input  logic                             rdy_ex,
    input  logic                             regWr_me,
    input  logic [REGW-1:0]                  regDst_me,
    input  logic [DATAW-1:0]                 res_me,
    input  logic                             rdy_me,
    input  logic                             regWr_wb,
    input  logic [REGW-1:0]                  regDst_wb,
    input  logic [DATAW-1:0]                 wdat_wb,
    input  logic                             flush,
    input  logic [NSRC-1:0][REGW-1:0]        src,
    output logic [NSRC-1:0][DATAW-1:0]       fwd,
    output logic [NSRC-1:0]                  fwd_hit,
    output logic                             stall,
    output logic [3:0]                       stall_cnt,
    output logic                             timeout
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [4:0]  MAXS = 5'(MAXSTALL);

    typedef enum logic {IDLE, STALL} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             cnt_nxt;
    logic                   timeout_set;

    logic [DEPTH-1:0]       hv;
    logic [REGW-1:0]        hreg  [DEPTH];
    logic [DATAW-1:0]       hdata [DEPTH];
    logic [PW-1:0]          wptr;

    logic [NSRC-1:0]        req;
    logic                   wb_we;
    logic                   done;
    logic [PW-1:0]          idx;

    // Per-port priority lookup across producers and history, newest entry first.
    always_comb begin
        fwd     = '0;
        fwd_hit = '0;
        req     = '0;
        done    = 1'b0;
        idx     = '0;
        for (int p = 0; p < NSRC; p++) begin
            done = 1'b0;
            if (src[p] == '0) begin
                done = 1'b1;
            end else if (regWr_ex && (regDst_ex == src[p])) begin
                done = 1'b1;
                if (rdy_ex) begin
                    fwd_hit[p] = 1'b1;
                    fwd[p]     = res_ex;
                end else begin
                    req[p] = 1'b1;
                end
            end else if (regWr_me && (regDst_me == src[p])) begin
                done = 1'b1;
                if (rdy_me) begin
                    fwd_hit[p] = 1'b1;
                    fwd[p]     = res_me;
                end else begin
                    req[p] = 1'b1;
                end
            end
            for (int k = 1; k <= DEPTH; k++) begin
                idx = wptr - PW'(k);
                if (!done && hv[idx] && (hreg[idx] == src[p])) begin
                    done       = 1'b1;
                    fwd_hit[p] = 1'b1;
                    fwd[p]     = hdata[idx];
                end
            end
        end
    end

    assign stall = |req;
    assign wb_we = regWr_wb && (regDst_wb != '0) && !stall;

    // Stall FSM next state, saturating run-length counter and timeout detect.
    always_comb begin
        state_nxt   = IDLE;
        cnt_nxt     = 4'd0;
        timeout_set = 1'b0;
        if (stall) begin
            state_nxt = STALL;
        end
        if (state_nxt == STALL) begin
            cnt_nxt = (stall_cnt == 4'd15) ? 4'd15 : stall_cnt + 4'd1;
            if ({1'b0, cnt_nxt} == MAXS) begin
                timeout_set = 1'b1;
            end
        end
    end

    // Stall state register; flush abandons the current stall run.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            stall_cnt <= 4'd0;
            timeout   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            stall_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= cnt_nxt;
            if (timeout_set) begin
                timeout <= 1'b1;
            end
        end
    end

    // Circular writeback history; a commit overwrites the oldest entry when full.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hv   <= '0;
            wptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hreg[i]  <= '0;
                hdata[i] <= '0;
            end
        end else if (flush) begin
            hv   <= '0;
            wptr <= '0;
        end else if (wb_we) begin
            hv[wptr]    <= 1'b1;
            hreg[wptr]  <= regDst_wb;
            hdata[wptr] <= wdat_wb;
            wptr        <= wptr + PW'(1);
        end
    end

endmodule

// File: tb/tb_forward_buffer.sv
// Directed bench for forward_buffer: lookup priority table plus
// hand-written history, stall, timeout, flush and reset sequences.
module tb_forward_buffer;

    logic              CLK = 1'b0;
    logic              RST;
    logic              regWr_ex, rdy_ex, regWr_me, rdy_me, regWr_wb, flush;
    logic [4:0]        regDst_ex, regDst_me, regDst_wb;
    logic [31:0]       res_ex, res_me, wdat_wb;
    logic [1:0][4:0]   src;
    logic [1:0][31:0]  fwd;
    logic [1:0]        fwd_hit;
    logic              stall;
    logic [3:0]        stall_cnt;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    forward_buffer dut (
        .CLK(CLK), .RST(RST),
        .regWr_ex(regWr_ex), .regDst_ex(regDst_ex), .res_ex(res_ex), .rdy_ex(rdy_ex),
        .regWr_me(regWr_me), .regDst_me(regDst_me), .res_me(res_me), .rdy_me(rdy_me),
        .regWr_wb(regWr_wb), .regDst_wb(regDst_wb), .wdat_wb(wdat_wb),
        .flush(flush), .src(src), .fwd(fwd), .fwd_hit(fwd_hit),
        .stall(stall), .stall_cnt(stall_cnt), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wex; logic [4:0] dex; logic [31:0] rex; logic yex;
        logic        wme; logic [4:0] dme; logic [31:0] rme; logic yme;
        logic [4:0]  s0;  logic [4:0] s1;
        logic [31:0] f0;  logic h0;  logic [31:0] f1;  logic h1;  logic st;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] d);
        @(negedge CLK);
        regWr_wb  = 1'b1;
        regDst_wb = r;
        wdat_wb   = d;
        @(negedge CLK);
        regWr_wb  = 1'b0;
    endtask

    initial begin
        //           wex dex rex     yex wme dme rme     yme s0 s1  f0      h0 f1      h1 st
        vt[0] = '{1, 8, 32'h11, 1, 1, 8, 32'h22, 1, 8, 0, 32'h11, 1, 32'h0,  0, 0};
        vt[1] = '{0, 8, 32'h11, 1, 1, 8, 32'h22, 1, 8, 8, 32'h22, 1, 32'h22, 1, 0};
        vt[2] = '{1, 8, 32'h11, 0, 1, 8, 32'h22, 1, 8, 0, 32'h0,  0, 32'h0,  0, 1};
        vt[3] = '{1, 0, 32'h55, 1, 0, 0, 32'h0,  1, 0, 0, 32'h0,  0, 32'h0,  0, 0};
        vt[4] = '{1, 8, 32'h11, 1, 1, 9, 32'h33, 1, 7, 3, 32'h0,  0, 32'h0,  0, 0};
        vt[5] = '{1, 8, 32'h44, 1, 1, 9, 32'h33, 1, 8, 9, 32'h44, 1, 32'h33, 1, 0};
        vt[6] = '{1, 8, 32'h44, 1, 1, 9, 32'h33, 0, 8, 9, 32'h44, 1, 32'h0,  0, 1};

        RST = 1'b1;
        regWr_ex = 0; regDst_ex = 0; res_ex = 0; rdy_ex = 0;
        regWr_me = 0; regDst_me = 0; res_me = 0; rdy_me = 0;
        regWr_wb = 0; regDst_wb = 0; wdat_wb = 0; flush = 0;
        src = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Producer priority and gating, history empty.
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            regWr_ex = vt[i].wex; regDst_ex = vt[i].dex; res_ex = vt[i].rex; rdy_ex = vt[i].yex;
            regWr_me = vt[i].wme; regDst_me = vt[i].dme; res_me = vt[i].rme; rdy_me = vt[i].yme;
            src[0] = vt[i].s0; src[1] = vt[i].s1;
            #1;
            chk($sformatf("v%0d_fwd0", i), fwd[0], vt[i].f0);
            chk($sformatf("v%0d_hit0", i), 32'(fwd_hit[0]), 32'(vt[i].h0));
            chk($sformatf("v%0d_fwd1", i), fwd[1], vt[i].f1);
            chk($sformatf("v%0d_hit1", i), 32'(fwd_hit[1]), 32'(vt[i].h1));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].st));
        end
        @(negedge CLK);
        regWr_ex = 0; regWr_me = 0; rdy_ex = 1; rdy_me = 1; src = '0;
        @(negedge CLK);
        chk("idle_cnt", 32'(stall_cnt), 32'd0);

        // History: commits 1..5 into a 4-deep buffer; same-cycle commit invisible.
        for (int r = 1; r <= 5; r++) begin
            @(negedge CLK);
            regWr_wb = 1; regDst_wb = 5'(r); wdat_wb = 32'h100 + 32'(r); src[0] = 5'(r);
            #1;
            chk($sformatf("same_cycle_hit_r%0d", r), 32'(fwd_hit[0]), 32'd0);
        end
        @(negedge CLK);
        regWr_wb = 0; src[0] = 5'd1;
        #1;
        chk("hist_r1_evicted", 32'(fwd_hit[0]), 32'd0);
        for (int r = 2; r <= 5; r++) begin
            src[1] = 5'(r);
            #1;
            chk($sformatf("hist_r%0d_hit", r), 32'(fwd_hit[1]), 32'd1);
            chk($sformatf("hist_r%0d_data", r), fwd[1], 32'h100 + 32'(r));
        end
        commit(5'd3, 32'h999);
        src[0] = 5'd3;
        #1;
        chk("hist_newer_r3", fwd[0], 32'h999);
        src[0] = 5'd2;
        #1;
        chk("hist_r2_overwritten", 32'(fwd_hit[0]), 32'd0);
        commit(5'd0, 32'hDEAD);
        commit(5'd6, 32'h600);
        src[0] = 5'd4; src[1] = 5'd6;
        #1;
        chk("r0_commit_no_advance", fwd[0], 32'h104);
        chk("hist_r6", fwd[1], 32'h600);
        src[0] = 5'd3;
        #1;
        chk("hist_r3_kept", fwd[0], 32'h999);

        // Flush empties history.
        @(negedge CLK);
        flush = 1;
        @(negedge CLK);
        flush = 0; src[0] = 5'd4;
        #1;
        chk("flush_r4_miss", 32'(fwd_hit[0]), 32'd0);
        src = '0;

        // Load stall for 3 cycles then data arrives.
        @(negedge CLK);
        regWr_me = 1; regDst_me = 5'd9; rdy_me = 0; res_me = 0; src[1] = 5'd9;
        #1;
        chk("load_stall", 32'(stall), 32'd1);
        chk("load_nohit", 32'(fwd_hit[1]), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("load_cnt%0d", i), 32'(stall_cnt), 32'(i));
        end
        @(negedge CLK);
        rdy_me = 1; res_me = 32'hABCD;
        #1;
        chk("load_fwd", fwd[1], 32'hABCD);
        chk("load_hit", 32'(fwd_hit[1]), 32'd1);
        chk("load_unstall", 32'(stall), 32'd0);
        @(posedge CLK);
        #1;
        chk("load_cnt_clr", 32'(stall_cnt), 32'd0);

        // Long stall: saturation and sticky timeout.
        @(negedge CLK);
        rdy_me = 0;
        for (int i = 1; i <= 17; i++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("to_cnt%0d", i), 32'(stall_cnt), (i > 15) ? 32'd15 : 32'(i));
            chk($sformatf("to_flag%0d", i), 32'(timeout), (i >= 15) ? 32'd1 : 32'd0);
        end
        @(negedge CLK);
        rdy_me = 1;
        @(posedge CLK);
        #1;
        chk("to_stall_clear", 32'(stall), 32'd0);
        chk("to_cnt_clear", 32'(stall_cnt), 32'd0);
        chk("to_sticky", 32'(timeout), 32'd1);
        @(negedge CLK);
        regWr_me = 0; src = '0;
        commit(5'd7, 32'h77);
        src[0] = 5'd7;
        #1;
        chk("pre_flush_r7", fwd[0], 32'h77);
        @(negedge CLK);
        flush = 1;
        @(negedge CLK);
        flush = 0;
        #1;
        chk("flush2_r7_miss", 32'(fwd_hit[0]), 32'd0);
        chk("flush_keeps_timeout", 32'(timeout), 32'd1);

        // Async reset in the middle of a stall.
        @(negedge CLK);
        src = '0; regWr_me = 1; regDst_me = 5'd9; rdy_me = 0; src[1] = 5'd9;
        repeat (2) @(posedge CLK);
        #1;
        chk("mid_cnt2", 32'(stall_cnt), 32'd2);
        RST = 1;
        #1;
        chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_mid_timeout", 32'(timeout), 32'd0);
        @(negedge CLK);
        regWr_me = 0; src = '0;
        @(negedge CLK);
        RST = 0;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/forward_buffer.md
FORWARD_BUFFER -- requirements
Module: forward_buffer

Interface
REQ-001 The block SHALL provide parameter NSRC, default 2, meaning number of independent operand lookup ports.
REQ-002 The block SHALL provide parameter DEPTH, default 4, meaning number of committed writebacks held in the history buffer (power of two, 2..16).
REQ-003 The block SHALL provide parameter DATAW, default 32, meaning data width; REGW, default 5, meaning register index width.
REQ-004 The block SHALL provide parameter MAXSTALL, default 15, meaning stall cycles before a timeout error.
REQ-005 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 regWr_ex, regDst_ex[REGW], res_ex[DATAW], rdy_ex  in  EX-stage producer: write enable, destination, result, result valid (0 for loads).
REQ-008 regWr_me, regDst_me[REGW], res_me[DATAW], rdy_me  in  MEM-stage producer; rdy_me=0 while a load awaits dhit.
REQ-009 regWr_wb, regDst_wb[REGW], wdat_wb[DATAW]  in  WB commit, pushed into history buffer.
REQ-010 flush  in  1  discards the history buffer and stall state.
REQ-011 src[NSRC][REGW]  in  operand register indices from the consuming stage.
REQ-012 fwd[NSRC][DATAW]  out  forwarded value per port; fwd_hit[NSRC]  out  1 when fwd is valid and must replace the register file value.
REQ-013 stall  out  1  freeze consumer and upstream stages; stall_cnt[4]  out  current stall run length; timeout  out  1  sticky error.

Function
REQ-014 Lookup for each port SHALL be combinational; priority EX > MEM > history newest > history oldest; first match wins.
REQ-015 A producer SHALL match only if its write enable is 1 and its destination equals src and src != 0; src=0 SHALL yield fwd_hit=0, fwd=0.
REQ-016 A match on a producer with rdy=0 SHALL give fwd_hit=0 for that port and SHALL request a stall; lower-priority matches SHALL NOT be used.
REQ-017 No match on any producer or history entry SHALL give fwd_hit=0, fwd=0.
REQ-018 History buffer SHALL be a circular buffer of DEPTH entries {valid, reg, data} with write pointer wrapping DEPTH-1 -> 0.
REQ-019 Each cycle with regWr_wb=1, regDst_wb!=0, and stall=0 SHALL write one entry at the pointer and advance it; when full the oldest entry SHALL be overwritten.
REQ-020 Two history entries with the same reg SHALL resolve to the newer one.
REQ-021 A WB commit and a lookup in the same cycle SHALL NOT see the new entry; WB data becomes forwardable from history the next cycle (WB port is not a direct forward source).
REQ-022 Stall FSM states IDLE and STALL; IDLE->STALL when any port requests stall; STALL->IDLE when no port requests stall.
REQ-023 stall output SHALL equal the OR of port stall requests (combinational, not delayed by FSM state).
REQ-024 stall_cnt SHALL increment each cycle in STALL, saturate at 15, and clear to 0 on entry to IDLE.
REQ-025 timeout SHALL set when stall_cnt reaches MAXSTALL while in STALL, and remain 1 until reset.
REQ-026 flush SHALL, at the next edge, clear all valid bits, the pointer, stall_cnt, and return the FSM to IDLE; flush takes precedence over a simultaneous WB commit.

Reset
REQ-027 While RST=1, all history entries SHALL be invalid, pointer=0, FSM=IDLE, stall_cnt=0, timeout=0; combinational outputs follow from this state and the inputs.
REQ-028 Deassertion of RST SHALL take effect with no spurious history write; assertion mid-stall SHALL immediately clear stall_cnt and timeout.

Verification
REQ-029 regWr_ex=1, regDst_ex=8, res_ex=0x11, rdy_ex=1; regWr_me=1, regDst_me=8, res_me=0x22; src[0]=8 -> fwd[0]=0x11, fwd_hit[0]=1, stall=0.
REQ-030 MEM load regDst_me=9, rdy_me=0 held 3 cycles then rdy_me=1 with res_me=0xABCD; src[1]=9 -> stall=1 for 3 cycles, stall_cnt 1,2,3 after each edge, then fwd[1]=0xABCD, hit=1, stall=0, stall_cnt=0.
REQ-031 Commit regs 1..5 with data 0x100+reg over 5 cycles (DEPTH=4) -> src=1 misses, src=2..5 hit with 0x102..0x105; commit reg 3 data 0x999 -> src=3 gives 0x999.
REQ-032 src[0]=0 while EX writes reg 0 -> fwd_hit[0]=0, fwd[0]=0; regWr_wb=1 with regDst_wb=0 -> pointer unchanged.
REQ-033 Hold rdy_me=0 on a matched load for MAXSTALL+2 cycles -> stall_cnt saturates at 15, timeout=1 and stays 1 after stall clears; assert flush -> history empty, timeout still 1; assert RST -> timeout=0.
